// File: rtl/demux_serial_driver_pkg.sv
// demux_pkg: shared definitions for the demux serial driver.
//   drv_state_t : driver FSM state encoding (IDLE, SHIFT, GAP)
//   LANE0..LANE3: demux output lane select codes
//   frame_len   : enabled bits per frame for a given data width and parity option
package demux_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } drv_state_t;

    localparam logic [1:0] LANE0 = 2'd0;
    localparam logic [1:0] LANE1 = 2'd1;
    localparam logic [1:0] LANE2 = 2'd2;
    localparam logic [1:0] LANE3 = 2'd3;

    function automatic int frame_len(input int width, input bit parity_en);
        return parity_en ? width + 1 : width;
    endfunction

endpackage

// File: rtl/demux_serial_driver_piso_shreg.sv
// piso_shreg: parallel-in / serial-out shift register, MSB first.
// Ports:
//   clk, rst_n : clock, async active-low reset (clears the register)
//   i_load     : load i_data (takes priority over shift)
//   i_shift    : shift left by one, zero fill
//   i_data     : parallel load word
//   o_msb      : current MSB (registered)
// Zero fill means the register is empty after W shifts, so o_msb idles at 0.
module piso_shreg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic         i_shift,
    input  logic [W-1:0] i_data,
    output logic         o_msb
);

    logic [W-1:0] r_sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh <= '0;
        end else if (i_load) begin
            r_sh <= i_data;
        end else if (i_shift) begin
            r_sh <= {r_sh[W-2:0], 1'b0};
        end
    end

    assign o_msb = r_sh[W-1];

endmodule

// File: rtl/demux_serial_driver.sv
// demux_serial_driver: accepts a word + 2-bit lane over valid/ready and
// serialises it MSB-first onto the 1-to-4 demux inputs (a, e, s).
// Parameters: WIDTH (data bits, 2..32), GAP (idle cycles after each frame, >= 0).
// Ports:
//   clk, rst_n         : clock, async active-low reset
//   in_valid/in_ready  : input handshake (in_ready combinational, high in IDLE)
//   in_data, in_dest   : word to send and demux lane
//   a, e, s            : demux data, enable, select (registered)
//   busy               : high while shifting or in the post-frame gap
//   done               : one-cycle pulse after the last frame bit
// Build option: DEMUX_SERIAL_PARITY_EN appends an even-parity bit to each frame.
//
// State | meaning
// IDLE  | waiting for a handshake, in_ready high
// SHIFT | frame bits on a, e high
// GAP   | e low for GAP cycles before returning to IDLE
module demux_serial_driver
    import demux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_dest,
    output logic             a,
    output logic             e,
    output logic [1:0]       s,
    output logic             busy,
    output logic             done
);

`ifdef DEMUX_SERIAL_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    localparam int FRAME = frame_len(WIDTH, PAR_EN);
    localparam int CW    = $clog2(WIDTH + 1);
    localparam int GW    = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [CW-1:0] CNT_LOAD = CW'(FRAME - 1);
    localparam logic [GW-1:0] GAP_LOAD = (GAP > 0) ? GW'(GAP - 1) : '0;

    // GAP the parameter shadows the imported state name, so states are
    // always referenced with the package scope.
    drv_state_t    r_state;
    logic [CW-1:0] r_cnt;
    logic [GW-1:0] r_gap_cnt;
    logic          r_e;
    logic [1:0]    r_s;
    logic          r_busy;
    logic          r_done;

    logic             w_accept;
    logic             w_shift;
    logic             w_msb;
    logic [FRAME-1:0] w_load_data;

`ifdef DEMUX_SERIAL_PARITY_EN
    assign w_load_data = {in_data, ^in_data};
`else
    assign w_load_data = in_data;
`endif

    assign in_ready = (r_state == demux_pkg::IDLE);
    assign w_accept = in_valid && in_ready;
    assign w_shift  = (r_state == demux_pkg::SHIFT);

    piso_shreg #(
        .W(FRAME)
    ) u_shreg (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_accept),
        .i_shift(w_shift),
        .i_data (w_load_data),
        .o_msb  (w_msb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= demux_pkg::IDLE;
            r_cnt     <= '0;
            r_gap_cnt <= '0;
            r_e       <= 1'b0;
            r_s       <= LANE0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                demux_pkg::IDLE: begin
                    if (in_valid) begin
                        r_s     <= in_dest;
                        r_cnt   <= CNT_LOAD;
                        r_e     <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= demux_pkg::SHIFT;
                    end
                end
                demux_pkg::SHIFT: begin
                    if (r_cnt == '0) begin
                        r_e    <= 1'b0;
                        r_done <= 1'b1;
                        if (GAP == 0) begin
                            r_busy  <= 1'b0;
                            r_state <= demux_pkg::IDLE;
                        end else begin
                            r_gap_cnt <= GAP_LOAD;
                            r_state   <= demux_pkg::GAP;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                demux_pkg::GAP: begin
                    if (r_gap_cnt == '0) begin
                        r_busy  <= 1'b0;
                        r_state <= demux_pkg::IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 1'b1;
                    end
                end
                default: begin
                    r_e     <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= demux_pkg::IDLE;
                end
            endcase
        end
    end

    assign a    = w_msb;
    assign e    = r_e;
    assign s    = r_s;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_demux_serial_driver.sv
// Bench for demux_serial_driver: one instance at WIDTH=8/GAP=1, one at
// WIDTH=4/GAP=0. A cycle-offset reference model (cycles since the last
// accepted word) predicts every output each cycle.
module tb_demux_serial_driver;

    localparam int W8 = 8;
    localparam int G8 = 1;
    localparam int W4 = 4;
    localparam int G4 = 0;
`ifdef DEMUX_SERIAL_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FR8 = W8 + PAR;
    localparam int FR4 = W4 + PAR;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       v8 = 1'b0, v4 = 1'b0;
    logic [7:0] d8 = '0;
    logic [3:0] d4 = '0;
    logic [1:0] dst8 = '0, dst4 = '0;
    logic       rdy8, a8, e8, busy8, done8;
    logic       rdy4, a4, e4, busy4, done4;
    logic [1:0] s8, s4;

    demux_serial_driver #(.WIDTH(W8), .GAP(G8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(rdy8),
        .in_data(d8), .in_dest(dst8), .a(a8), .e(e8), .s(s8),
        .busy(busy8), .done(done8)
    );

    demux_serial_driver #(.WIDTH(W4), .GAP(G4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(rdy4),
        .in_data(d4), .in_dest(dst4), .a(a4), .e(e4), .s(s4),
        .busy(busy4), .done(done4)
    );

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    // reference model, index 0 = dut8, 1 = dut4
    bit          m_act[2];
    int          m_k[2];
    logic [32:0] m_bits[2];
    logic [1:0]  m_s[2];
    bit          m_acc[2];

    function automatic int frv(input int i);
        return (i == 0) ? FR8 : FR4;
    endfunction

    function automatic int gpv(input int i);
        return (i == 0) ? G8 : G4;
    endfunction

    function automatic int wdv(input int i);
        return (i == 0) ? W8 : W4;
    endfunction

    // frame bits, first-sent bit at index frame_len-1
    function automatic logic [32:0] mk_bits(input logic [31:0] d, input int w);
        logic [32:0] dd;
        dd = {1'b0, d} & ((33'd1 << w) - 33'd1);
        if (PAR != 0) return (dd << 1) | {32'd0, ^dd};
        return dd;
    endfunction

    function automatic bit m_ready(input int i);
        return !m_act[i] || (m_k[i] > frv(i) + gpv(i));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic check_dut(input int i, input logic oa, input logic oe, input logic [1:0] os,
                             input logic ob, input logic od, input logic orr);
        int  kk, f;
        bit  ex, ax;
        kk = m_k[i];
        f  = frv(i);
        ex = m_act[i] && kk >= 1 && kk <= f;
        ax = ex ? m_bits[i][f-kk] : 1'b0;
        chk((i == 0) ? "a8" : "a4", 32'(oa), 32'(ax));
        chk((i == 0) ? "e8" : "e4", 32'(oe), 32'(ex));
        chk((i == 0) ? "s8" : "s4", 32'(os), 32'(m_s[i]));
        chk((i == 0) ? "busy8" : "busy4", 32'(ob), 32'(m_act[i] && kk <= f + gpv(i)));
        chk((i == 0) ? "done8" : "done4", 32'(od), 32'(m_act[i] && kk == f + 1));
        chk((i == 0) ? "ready8" : "ready4", 32'(orr), 32'(m_ready(i)));
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 1'b0;
            m_k[i]   = 0;
            m_s[i]   = 2'b00;
            m_acc[i] = 1'b0;
        end
    endtask

    // one clock: model the edge from current inputs, then check #1 after it
    task automatic tick();
        bit acc0, acc1;
        acc0 = rst_n && v8 && m_ready(0);
        acc1 = rst_n && v4 && m_ready(1);
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            model_reset();
        end else begin
            m_acc[0] = acc0;
            m_acc[1] = acc1;
            for (int i = 0; i < 2; i++) begin
                if ((i == 0) ? acc0 : acc1) begin
                    m_act[i]  = 1'b1;
                    m_k[i]    = 1;
                    m_bits[i] = (i == 0) ? mk_bits(32'(d8), wdv(0)) : mk_bits(32'(d4), wdv(1));
                    m_s[i]    = (i == 0) ? dst8 : dst4;
                end else if (m_act[i] && m_k[i] < 1000) begin
                    m_k[i]++;
                end
            end
        end
        #1;
        check_dut(0, a8, e8, s8, busy8, done8, rdy8);
        check_dut(1, a4, e4, s4, busy4, done4, rdy4);
    endtask

    logic [8:0] cap;
    int         ecnt;
    int         t_first, t_second, guard;

    initial begin
        model_reset();

        // reset held, then released away from the clock edge
        repeat (3) tick();
        #2 rst_n = 1'b1;
        tick();
        chk("reset_s8", 32'(s8), 32'(2'b00));
        chk("reset_ready8", 32'(rdy8), 32'd1);

        // basic frame A5 to lane 2
        d8 = 8'hA5; dst8 = 2'd2; v8 = 1'b1;
        tick();
        v8 = 1'b0; cap = '0; ecnt = 0;
        repeat (FR8 + 4) begin
            if (e8) begin
                cap = {cap[7:0], a8};
                ecnt++;
            end
            tick();
        end
        chk("frame_a5_bits", 32'(cap), 32'(9'h0A5 << PAR));
        chk("frame_a5_len", 32'(ecnt), 32'(FR8));

        // back-to-back with valid held high
        d8 = 8'hFF; dst8 = demux_pkg::LANE3; v8 = 1'b1;
        guard = 0;
        do begin tick(); guard++; end while (!m_acc[0] && guard < 20);
        chk("b2b_first_accept", 32'(m_acc[0]), 32'd1);
        t_first = cyc;
        d8 = 8'h00; dst8 = demux_pkg::LANE1;
        guard = 0;
        do begin tick(); guard++; end while (!m_acc[0] && guard < 20);
        chk("b2b_second_accept", 32'(m_acc[0]), 32'd1);
        t_second = cyc;
        v8 = 1'b0;
        chk("b2b_interval", 32'(t_second - t_first), 32'(FR8 + G8 + 1));
        repeat (FR8 + 3) tick();

        // WIDTH=4, GAP=0: 4'h9 to lane 0
        d4 = 4'h9; dst4 = demux_pkg::LANE0; v4 = 1'b1;
        tick();
        v4 = 1'b0;
        repeat (FR4) tick();
        chk("g0_done_cycle", 32'(done4), 32'd1);
        chk("g0_ready_with_done", 32'(rdy4), 32'd1);
        repeat (3) tick();

        // handshake offered while busy is ignored
        d8 = 8'hA5; dst8 = 2'd2; v8 = 1'b1;
        tick();
        v8 = 1'b0;
        repeat (2) tick();
        d8 = 8'h3C; dst8 = 2'd1; v8 = 1'b1;
        tick();
        v8 = 1'b0;
        repeat (FR8 + 6) tick();
        chk("blocked_s", 32'(s8), 32'd2);
        chk("blocked_idle", 32'(busy8), 32'd0);

        // reset mid-frame
        d8 = 8'hA5; dst8 = 2'd2; v8 = 1'b1;
        d4 = 4'hF; dst4 = 2'd3; v4 = 1'b1;
        tick();
        v8 = 1'b0; v4 = 1'b0;
        repeat (2) tick();
        chk("pre_reset_a8", 32'(a8), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_e8", 32'(e8), 32'd0);
        chk("async_rst_a8", 32'(a8), 32'd0);
        chk("async_rst_s8", 32'(s8), 32'd0);
        chk("async_rst_s4", 32'(s4), 32'd0);
        chk("async_rst_ready8", 32'(rdy8), 32'd1);
        model_reset();
        repeat (2) tick();
        #2 rst_n = 1'b1;
        repeat (FR8 + 4) tick();

        // randomized traffic on both instances
        for (int n = 0; n < 600; n++) begin
            v8   = ($urandom_range(0, 2) == 0);
            d8   = 8'($urandom);
            dst8 = 2'($urandom);
            v4   = ($urandom_range(0, 1) == 0);
            d4   = 4'($urandom);
            dst4 = 2'($urandom);
            tick();
        end
        v8 = 1'b0; v4 = 1'b0;
        repeat (FR8 + 4) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
